// File: rtl/tg_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tg_stream_arbiter
//
// Merges RECEIVER_STREAMS 14-bit AXI-Stream traffic-generator outputs into a
// single AXI-Stream master. Streams are served round-robin. Each grant
// forwards exactly BURST_LEN beats, and the final beat of a burst carries
// TLAST. Every output beat is tagged with its source stream index on TID.
// A registered output stage decouples the downstream timing from the width of
// the input mux.
//
// Parameters
//   RECEIVER_STREAMS  number of input streams (2..16)
//   BURST_LEN         beats forwarded per grant (1..65535)
//   ID_W              TID width, 2**ID_W >= RECEIVER_STREAMS
//
// Ports
//   aclk, resetn      clock (rising edge) and asynchronous active-low reset
//   extenable         arbitration enable; low blocks new grants only
//   S_AXIS_TVALID     per-stream valid
//   S_AXIS_TDATA      flattened data, stream i at [14*i+13:14*i]
//   S_AXIS_TREADY     per-stream ready, only the granted stream can be high
//   M_AXIS_TVALID/TDATA/TID/TLAST/TREADY   merged output stream
//   busy              high while a burst grant is active
// -----------------------------------------------------------------------------
module tg_stream_arbiter #(
  parameter int RECEIVER_STREAMS = 8,
  parameter int BURST_LEN        = 16,
  parameter int ID_W             = 3
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           extenable,
  input  logic [RECEIVER_STREAMS-1:0]    S_AXIS_TVALID,
  input  logic [RECEIVER_STREAMS*14-1:0] S_AXIS_TDATA,
  output logic [RECEIVER_STREAMS-1:0]    S_AXIS_TREADY,
  output logic                           M_AXIS_TVALID,
  output logic [13:0]                    M_AXIS_TDATA,
  output logic [ID_W-1:0]                M_AXIS_TID,
  output logic                           M_AXIS_TLAST,
  input  logic                           M_AXIS_TREADY,
  output logic                           busy
);

  localparam int                DATA_W    = 14;
  localparam int                CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]   PTR_RESET = ID_W'(RECEIVER_STREAMS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ID_W-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  // Output register stage
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_tid_q, out_tid_d;
  logic                out_last_q, out_last_d;

  // ---------------------------------------------------------------------------
  // Round-robin search
  //
  // The search order is rr_ptr+1 .. N-1, then 0 .. rr_ptr. Two priority
  // scans with constant indices give that order without a rotator: the first
  // requester above the pointer wins, otherwise the first one at or below it.
  // ---------------------------------------------------------------------------
  logic                found_hi, found_lo;
  logic [ID_W-1:0]     pick_hi, pick_lo;
  logic [ID_W-1:0]     arb_pick;
  logic                any_req;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < RECEIVER_STREAMS; i++) begin
      if (S_AXIS_TVALID[i]) begin
        if (ID_W'(i) > rr_ptr_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            pick_hi  = ID_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          pick_lo  = ID_W'(i);
        end
      end
    end
  end

  assign any_req  = |S_AXIS_TVALID;
  assign arb_pick = found_hi ? pick_hi : pick_lo;

  // ---------------------------------------------------------------------------
  // Granted-stream select
  // ---------------------------------------------------------------------------
  logic [RECEIVER_STREAMS-1:0] gnt_onehot;
  logic                        gnt_valid;
  logic [DATA_W-1:0]           gnt_data;

  always_comb begin
    gnt_onehot = '0;
    gnt_data   = '0;
    for (int i = 0; i < RECEIVER_STREAMS; i++) begin
      gnt_onehot[i] = (gnt_q == ID_W'(i));
      if (gnt_q == ID_W'(i)) begin
        gnt_data = S_AXIS_TDATA[DATA_W*i +: DATA_W];
      end
    end
  end

  assign gnt_valid = |(S_AXIS_TVALID & gnt_onehot);

  // The output slot can take a beat when it is empty or is being drained this
  // cycle. Ready is built only from register state and M_AXIS_TREADY, so no
  // combinational path exists from any S_AXIS_TVALID to S_AXIS_TREADY.
  logic slot_free;
  logic in_grant;
  logic accept;
  logic last_beat;

  assign slot_free = !out_valid_q || M_AXIS_TREADY;
  assign in_grant  = (state_q == GRANT);
  assign accept    = in_grant && gnt_valid && slot_free;
  assign last_beat = (beat_cnt_q == LAST_CNT);

  always_comb begin
    S_AXIS_TREADY = '0;
    for (int i = 0; i < RECEIVER_STREAMS; i++) begin
      S_AXIS_TREADY[i] = in_grant && gnt_onehot[i] && slot_free;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tid_d   = out_tid_q;
    out_last_d  = out_last_q;

    // Drain first; a load in the same cycle overrides it, which is what gives
    // back-to-back beats inside a burst. Payload is left untouched on drain so
    // it stays stable under backpressure.
    if (out_valid_q && M_AXIS_TREADY) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // The pointer moves only when a grant is issued, so a stream that
        // keeps requesting is reached within RECEIVER_STREAMS-1 bursts.
        if (extenable && any_req) begin
          state_d    = GRANT;
          gnt_d      = arb_pick;
          rr_ptr_d   = arb_pick;
          beat_cnt_d = '0;
        end
      end

      GRANT: begin
        // A granted stream that stalls simply holds the grant; extenable is
        // not consulted until the burst has delivered its last beat.
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = gnt_data;
          out_tid_d   = gnt_q;
          out_last_d  = last_beat;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= PTR_RESET;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // NOTE: the payload registers are reset as well as the valid flag, so the
  // master interface presents all-zero outputs while reset is asserted and a
  // beat caught mid-flight is discarded entirely.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tid_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tid_q   <= out_tid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TID    = out_tid_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign busy          = in_grant;

endmodule

// File: tb/tb_tg_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tg_stream_arbiter
//
// Two instances share one clock:
//   dut_a  8 streams, 4-beat bursts: ordering, sparse requesters,
//          backpressure, extenable and mid-burst reset.
//   dut_b  2 streams, 1-beat bursts: alternation and idle spacing.
// Every accepted input beat is pushed to a per-DUT expectation queue and
// popped when the matching output beat is transferred.
// -----------------------------------------------------------------------------
module tb_tg_stream_arbiter;

  localparam int N_A   = 8;
  localparam int BL_A  = 4;
  localparam int IDW_A = 3;
  localparam int N_B   = 2;
  localparam int BL_B  = 1;
  localparam int IDW_B = 1;
  localparam int DW    = 14;

  typedef struct {
    logic [2:0]    tid;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  // DUT A signals
  logic                resetn_a;
  logic                ext_a;
  logic [N_A-1:0]      tvalid_a;
  logic [N_A*DW-1:0]   tdata_a;
  logic [N_A-1:0]      tready_a;
  logic                m_valid_a;
  logic [DW-1:0]       m_data_a;
  logic [IDW_A-1:0]    m_tid_a;
  logic                m_last_a;
  logic                m_ready_a;
  logic                busy_a;

  // DUT B signals
  logic                resetn_b;
  logic                ext_b;
  logic [N_B-1:0]      tvalid_b;
  logic [N_B*DW-1:0]   tdata_b;
  logic [N_B-1:0]      tready_b;
  logic                m_valid_b;
  logic [DW-1:0]       m_data_b;
  logic [IDW_B-1:0]    m_tid_b;
  logic                m_last_b;
  logic                m_ready_b;
  logic                busy_b;

  tg_stream_arbiter #(
    .RECEIVER_STREAMS(N_A), .BURST_LEN(BL_A), .ID_W(IDW_A)
  ) dut_a (
    .aclk(aclk), .resetn(resetn_a), .extenable(ext_a),
    .S_AXIS_TVALID(tvalid_a), .S_AXIS_TDATA(tdata_a), .S_AXIS_TREADY(tready_a),
    .M_AXIS_TVALID(m_valid_a), .M_AXIS_TDATA(m_data_a), .M_AXIS_TID(m_tid_a),
    .M_AXIS_TLAST(m_last_a), .M_AXIS_TREADY(m_ready_a), .busy(busy_a)
  );

  tg_stream_arbiter #(
    .RECEIVER_STREAMS(N_B), .BURST_LEN(BL_B), .ID_W(IDW_B)
  ) dut_b (
    .aclk(aclk), .resetn(resetn_b), .extenable(ext_b),
    .S_AXIS_TVALID(tvalid_b), .S_AXIS_TDATA(tdata_b), .S_AXIS_TREADY(tready_b),
    .M_AXIS_TVALID(m_valid_b), .M_AXIS_TDATA(m_data_b), .M_AXIS_TID(m_tid_b),
    .M_AXIS_TLAST(m_last_b), .M_AXIS_TREADY(m_ready_b), .busy(busy_b)
  );

  // Bookkeeping
  int      n_checks = 0;
  int      n_pass   = 0;
  beat_t   exp_a[$];
  beat_t   exp_b[$];
  int      grant_log[$];
  int      sent_a[N_A];
  int      sent_b[N_B];
  int      acc_a = 0;
  int      acc_b = 0;
  logic    stall_a = 1'b0;
  logic [DW-1:0]    held_data;
  logic [IDW_A-1:0] held_tid;
  logic    held_last;
  int      b_gap = 0;
  logic    b_seen = 1'b0;
  logic    b_next_tid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
  endtask

  // Source data: stream id in the top nibble, per-stream sequence number below.
  function automatic logic [DW-1:0] data_word(input int s, input int k);
    logic [3:0] sid;
    logic [9:0] seq;
    sid = 4'(s);
    seq = 10'(k);
    return {sid, seq};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_A; i++) tdata_a[DW*i +: DW] = data_word(i, sent_a[i]);
    for (int i = 0; i < N_B; i++) tdata_b[DW*i +: DW] = data_word(i, sent_b[i]);
  endtask

  // One clock cycle: called and returning at a falling edge. Samples 1 time
  // unit after the falling edge, checks outputs, records input handshakes,
  // then advances the source counters after the rising edge has been taken.
  task automatic step();
    beat_t          e;
    logic [N_A-1:0] hs_a;
    logic [N_B-1:0] hs_b;
    #1;
    // ---- DUT A: payload stability under backpressure
    if (stall_a) begin
      check("a_hold_valid", 32'(m_valid_a), 32'(1));
      check("a_hold_data",  32'(m_data_a),  32'(held_data));
      check("a_hold_tid",   32'(m_tid_a),   32'(held_tid));
      check("a_hold_last",  32'(m_last_a),  32'(held_last));
    end
    stall_a   = m_valid_a && !m_ready_a;
    held_data = m_data_a;
    held_tid  = m_tid_a;
    held_last = m_last_a;
    // ---- DUT A: output beat against scoreboard
    if (m_valid_a && m_ready_a) begin
      if (exp_a.size() == 0) begin
        check("a_extra_beat", 32'(m_valid_a), 32'(0));
      end else begin
        e = exp_a.pop_front();
        check("a_tid",  32'(m_tid_a),  32'(e.tid));
        check("a_data", 32'(m_data_a), 32'(e.data));
        check("a_last", 32'(m_last_a), 32'(e.last));
      end
    end
    // ---- DUT A: ready rules
    if (!busy_a || (m_valid_a && !m_ready_a)) begin
      check("a_tready_blocked", 32'(tready_a), 32'(0));
    end else begin
      check("a_tready_onehot", 32'($countones(tready_a)), 32'(1));
      check("a_tready_foreign", 32'(tready_a & ~tvalid_a), 32'(0));
    end
    hs_a = tvalid_a & tready_a;
    for (int i = 0; i < N_A; i++) begin
      if (hs_a[i]) begin
        if (acc_a % BL_A == 0) grant_log.push_back(i);
        e.tid  = 3'(i);
        e.data = data_word(i, sent_a[i]);
        e.last = ((acc_a % BL_A) == BL_A - 1);
        exp_a.push_back(e);
        acc_a++;
      end
    end
    // ---- DUT B: one-beat bursts, alternating streams, one idle cycle between
    b_gap++;
    if (m_valid_b && m_ready_b) begin
      if (b_seen) check("b_gap", 32'(b_gap), 32'(2));
      b_seen = 1'b1;
      b_gap  = 0;
      check("b_tid_alt", 32'(m_tid_b), 32'(b_next_tid));
      b_next_tid = ~b_next_tid;
      if (exp_b.size() == 0) begin
        check("b_extra_beat", 32'(m_valid_b), 32'(0));
      end else begin
        e = exp_b.pop_front();
        check("b_tid",  32'(m_tid_b),  32'(e.tid));
        check("b_data", 32'(m_data_b), 32'(e.data));
        check("b_last", 32'(m_last_b), 32'(e.last));
      end
    end
    hs_b = tvalid_b & tready_b;
    for (int i = 0; i < N_B; i++) begin
      if (hs_b[i]) begin
        e.tid  = 3'(i);
        e.data = data_word(i, sent_b[i]);
        e.last = ((acc_b % BL_B) == BL_B - 1);
        exp_b.push_back(e);
        acc_b++;
      end
    end
    @(posedge aclk);
    @(negedge aclk);
    for (int i = 0; i < N_A; i++) if (hs_a[i]) sent_a[i]++;
    for (int i = 0; i < N_B; i++) if (hs_b[i]) sent_b[i]++;
    drive_data();
  endtask

  // Run until n grants are logged and the last one has completed its burst.
  task automatic run_bursts(input int n, input string tag);
    int budget;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!(grant_log.size() >= n && (acc_a % BL_A) == 0 && !busy_a) && budget < 400);
    if (budget >= 400) check({tag, "_timeout"}, 32'(budget), 32'(0));
  endtask

  // Run until the current burst on dut_a has accepted `beats` beats.
  task automatic run_to_beat(input int beats, input string tag);
    int budget;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!(grant_log.size() >= 1 && (acc_a % BL_A) == beats) && budget < 100);
    if (budget >= 100) check({tag, "_timeout"}, 32'(budget), 32'(0));
  endtask

  // Compare logged grant order against expected ids packed 4 bits each.
  task automatic check_log(input string tag, input int n, input logic [63:0] ids);
    check({tag, "_count"}, 32'(grant_log.size()), 32'(n));
    for (int k = 0; k < n && k < grant_log.size(); k++) begin
      check(tag, 32'(grant_log[k]), 32'(ids[4*k +: 4]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_before;
    resetn_a  = 1'b0;
    resetn_b  = 1'b0;
    ext_a     = 1'b1;
    ext_b     = 1'b1;
    tvalid_a  = '1;
    tvalid_b  = '1;
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    for (int i = 0; i < N_A; i++) sent_a[i] = 0;
    for (int i = 0; i < N_B; i++) sent_b[i] = 0;
    drive_data();
    @(negedge aclk);
    step();
    // Reset state
    check("rst_valid", 32'(m_valid_a), 32'(0));
    check("rst_data",  32'(m_data_a),  32'(0));
    check("rst_tid",   32'(m_tid_a),   32'(0));
    check("rst_last",  32'(m_last_a),  32'(0));
    check("rst_busy",  32'(busy_a),    32'(0));
    check("rst_tready", 32'(tready_a), 32'(0));
    check("rst_b_valid", 32'(m_valid_b), 32'(0));
    resetn_a = 1'b1;
    resetn_b = 1'b1;

    // Phase 1: all streams request, strict rotation from stream 0 with wrap
    grant_log.delete();
    run_bursts(9, "p1");
    check_log("p1_order", 9, 64'h0_7654_3210);

    // Phase 2: sparse requesters 2 and 5
    tvalid_a = 8'b0010_0100;
    grant_log.delete();
    run_bursts(4, "p2");
    check_log("p2_order", 4, 64'h5252);

    // Phase 3: backpressure for 5 cycles mid-burst; pointer is at 5 -> 6
    tvalid_a = '1;
    grant_log.delete();
    run_to_beat(2, "p3_start");
    m_ready_a = 1'b0;
    repeat (5) step();
    m_ready_a = 1'b1;
    run_bursts(1, "p3");
    check_log("p3_order", 1, 64'h6);

    // Phase 4: extenable drops during a stream-3 burst
    tvalid_a = 8'b0001_1000;
    grant_log.delete();
    run_to_beat(1, "p4_start");
    ext_a = 1'b0;
    run_bursts(1, "p4");
    check_log("p4_order", 1, 64'h3);
    acc_before = acc_a;
    repeat (6) begin
      step();
      check("p4_idle_busy", 32'(busy_a), 32'(0));
    end
    check("p4_no_accept", 32'(acc_a), 32'(acc_before));
    ext_a = 1'b1;
    grant_log.delete();
    run_bursts(1, "p4_resume");
    check_log("p4_resume", 1, 64'h4);

    // Phase 5: asynchronous reset on beat 2 of a stream-5 burst
    tvalid_a = '1;
    grant_log.delete();
    run_to_beat(2, "p5_start");
    check_log("p5_pre", 1, 64'h5);
    resetn_a = 1'b0;
    #1;
    check("p5_rst_valid",  32'(m_valid_a), 32'(0));
    check("p5_rst_tready", 32'(tready_a),  32'(0));
    check("p5_rst_busy",   32'(busy_a),    32'(0));
    check("p5_rst_last",   32'(m_last_a),  32'(0));
    exp_a.delete();
    acc_a   = 0;
    stall_a = 1'b0;
    step();
    step();
    resetn_a = 1'b1;
    grant_log.delete();
    run_bursts(2, "p5");
    check_log("p5_order", 2, 64'h10);

    // Drain whatever dut_a still holds
    tvalid_a = '0;
    begin
      int budget;
      budget = 0;
      while (exp_a.size() != 0 && budget < 20) begin
        step();
        budget++;
      end
    end
    check("a_drained", 32'(exp_a.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tg_stream_arbiter.md
Name: tg_stream_arbiter

Overview:
- Round-robin arbiter that merges RECEIVER_STREAMS 14-bit AXI-Stream traffic-generator outputs into one AXI-Stream master.
- Each grant lasts a fixed burst of BURST_LEN beats. Every output beat is tagged with its source stream ID, and the last beat of each burst carries TLAST.
- Sits between the traffic-generator array and the single downstream consumer (DMA/FIFO). A registered output stage keeps timing closure independent of stream count.

Parameters:
- RECEIVER_STREAMS, 8, number of input streams (2..16).
- BURST_LEN, 16, beats forwarded per grant (1..65535).
- ID_W, 3, width of M_AXIS_TID; must satisfy 2**ID_W >= RECEIVER_STREAMS.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- extenable  in  1  arbitration enable; low = no new grant (a burst in progress completes).
- S_AXIS_TVALID  in  RECEIVER_STREAMS  per-stream valid.
- S_AXIS_TDATA  in  RECEIVER_STREAMS*14  flattened data; stream i occupies bits [14*i+13:14*i].
- S_AXIS_TREADY  out  RECEIVER_STREAMS  per-stream ready.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TDATA  out  14  output data.
- M_AXIS_TID  out  ID_W  source stream index of the current beat.
- M_AXIS_TLAST  out  1  last beat of a burst.
- M_AXIS_TREADY  in  1  downstream ready.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; rr_ptr=RECEIVER_STREAMS-1; beat_cnt=0. All outputs 0: M_AXIS_TVALID, TDATA, TID, TLAST, busy and all S_AXIS_TREADY. Reset mid-burst discards the burst and any registered beat; no TLAST is emitted.
- State IDLE:
  - If extenable=1 and any S_AXIS_TVALID=1, grant the first valid stream found searching (rr_ptr+1) mod N upward with wrap.
  - Then set gnt=that index, rr_ptr=gnt, beat_cnt=0, and go to GRANT next cycle.
  - Otherwise remain in IDLE.
  - No S_AXIS_TREADY is asserted in IDLE.
- State GRANT:
  - S_AXIS_TREADY[gnt] = (!M_AXIS_TVALID || M_AXIS_TREADY). This is the only ready high; all others are 0.
  - Combinational from the output register state only; never from S_AXIS_TVALID.
  - Input beat accepted when S_AXIS_TVALID[gnt] && S_AXIS_TREADY[gnt].
  - On accept: output register loads TDATA=stream gnt data, TID=gnt, TLAST=(beat_cnt==BURST_LEN-1), TVALID=1, and beat_cnt increments.
  - When the accepted beat has TLAST=1: beat_cnt clears and the state returns to IDLE on the next edge.
  - A granted stream dropping TVALID does not end the grant; the burst waits (no timeout).
  - extenable falling in GRANT has no effect until the burst ends.
  - busy=1 throughout GRANT.
- Output register:
  - When M_AXIS_TVALID && M_AXIS_TREADY with no new load, TVALID clears next edge.
  - Load and drain may occur in the same cycle, giving full throughput inside a burst.
  - TDATA, TID and TLAST are held stable while TVALID=1 and TREADY=0 (AXI rule).
- Latency and throughput:
  - 1 cycle from input accept to output valid.
  - One IDLE arbitration cycle between bursts; steady-state throughput BURST_LEN/(BURST_LEN+1).
- Fairness:
  - rr_ptr only advances on a grant.
  - A continuously requesting stream waits at most RECEIVER_STREAMS-1 bursts.
  - Single requester: it is re-granted back-to-back, with one IDLE cycle between bursts.
- BURST_LEN=1: every beat has TLAST=1 and arbitration runs after each beat.
- Counter widths: beat_cnt is clog2(BURST_LEN+1) bits and never wraps past BURST_LEN-1.

Test Plan:
- Reset/first grant: all 8 valid, extenable=1, M_AXIS_TREADY=1, BURST_LEN=4 -> first burst has TID=0, four beats with TLAST on the 4th; next burst TID=1; order 0..7 then wraps to 0.
- Sparse requesters: only streams 2 and 5 valid -> TID sequence 2,5,2,5 in 4-beat bursts; S_AXIS_TREADY never high for any other stream.
- Backpressure: drop M_AXIS_TREADY for 5 cycles mid-burst at beat 2 -> TDATA, TID and TLAST held constant, no beat lost or duplicated; granted stream's TREADY=0 while the register is full; beat count stays 4.
- extenable: deassert during beat 1 of a stream-3 burst -> burst completes with TLAST; busy falls and no new grant while low; re-assert -> next grant is stream 4.
- Reset mid-burst: assert resetn=0 on beat 2 of a burst -> TVALID=0 and all TREADY=0 immediately (async); after release, first grant is stream 0.
- BURST_LEN=1, N=2, both valid with incrementing data -> TID alternates 0,1 every beat pair with 1 idle cycle between, TLAST=1 on every beat, data in order per stream.
